// File: rtl/y_operand_stage_pkg.sv
// Shared constants for the EX-stage Y operand generator: operand modes,
// forwarding selects and the opcode that requests a zero-extended immediate.
package y_operand_stage_pkg;

    localparam logic [2:0] Y_B     = 3'd0;
    localparam logic [2:0] Y_SHAMT = 3'd1;
    localparam logic [2:0] Y_ZERO  = 3'd2;
    localparam logic [2:0] Y_IMM   = 3'd3;
    localparam logic [2:0] Y_UPPER = 3'd4;
    localparam logic [2:0] Y_CONST = 3'd5;

    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    // Opcode field instruction[31:27] that selects zero-extension.
    localparam logic [4:0] ZEXT_OP_DEFAULT = 5'b00110;

endpackage

// File: rtl/y_operand_stage_if.sv
// Operand/handshake bundle between ID/EX, the Y operand stage and the ALU.
interface y_operand_stage_if #(
    parameter int unsigned DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instruction;
    logic [DATA_W-1:0] b_reg;
    logic [DATA_W-1:0] b_fwd_mem;
    logic [DATA_W-1:0] b_fwd_wb;
    logic [1:0]        fwd_sel;
    logic [2:0]        y_sel;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] Y;
    logic              y_is_imm;

    modport master (
        output in_valid, instruction, b_reg, b_fwd_mem, b_fwd_wb,
               fwd_sel, y_sel, flush, out_ready,
        input  in_ready, out_valid, Y, y_is_imm
    );

    modport slave (
        input  in_valid, instruction, b_reg, b_fwd_mem, b_fwd_wb,
               fwd_sel, y_sel, flush, out_ready,
        output in_ready, out_valid, Y, y_is_imm
    );
endinterface

// File: rtl/y_operand_stage_sel.sv
// Combinational Y operand selection: immediate extension, shamt, upper
// immediate, constant and forwarded B.
module y_operand_sel
    import y_operand_stage_pkg::*;
#(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       IMM_W     = 16,
    parameter int unsigned       SHAMT_W   = 5,
    parameter logic [4:0]        ZEXT_OP   = ZEXT_OP_DEFAULT,
    parameter logic [DATA_W-1:0] CONST_VAL = 32'd4
) (
    input  logic [31:0]       instruction,
    input  logic [DATA_W-1:0] b_sel,
    input  logic [2:0]        y_sel,
    output logic [DATA_W-1:0] next_y,
    output logic              next_imm
);
    logic [IMM_W-1:0]  imm_s;
    logic [DATA_W-1:0] imm_ext_s;
    logic              unused_instr_s;

    // Only some instruction fields feed the selection.
    assign unused_instr_s = ^instruction;

    // Extend the immediate, then pick the operand for the requested mode.
    always_comb begin
        imm_s     = instruction[IMM_W-1:0];
        imm_ext_s = {DATA_W{1'b0}};
        next_y    = {DATA_W{1'b0}};
        next_imm  = 1'b0;
        if (instruction[31:27] == ZEXT_OP) begin
            imm_ext_s = {{(DATA_W-IMM_W){1'b0}}, imm_s};
        end else begin
            imm_ext_s = {{(DATA_W-IMM_W){imm_s[IMM_W-1]}}, imm_s};
        end
        case (y_sel)
            Y_B:     next_y = b_sel;
            Y_SHAMT: next_y = {{(DATA_W-SHAMT_W){1'b0}}, instruction[6+SHAMT_W-1:6]};
            Y_ZERO:  next_y = {DATA_W{1'b0}};
            Y_IMM: begin
                next_y   = imm_ext_s;
                next_imm = 1'b1;
            end
            Y_UPPER: begin
                next_y   = {imm_s, {(DATA_W-IMM_W){1'b0}}};
                next_imm = 1'b1;
            end
            Y_CONST: next_y = CONST_VAL;
            default: begin
                next_y   = {DATA_W{1'b0}};
                next_imm = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/y_operand_stage.sv
// EX-stage Y operand generator: forwarding mux, operand select and a
// registered output with a one-entry skid buffer on a valid/ready handshake.
module y_operand_stage
    import y_operand_stage_pkg::*;
#(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       IMM_W     = 16,
    parameter int unsigned       SHAMT_W   = 5,
    parameter logic [4:0]        ZEXT_OP   = ZEXT_OP_DEFAULT,
    parameter logic [DATA_W-1:0] CONST_VAL = 32'd4
) (
    input  logic             clk,
    input  logic             rst,
    y_operand_stage_if.slave bus
);
    logic [DATA_W-1:0] b_sel_s;
    logic [DATA_W-1:0] next_y_s;
    logic              next_imm_s;
    logic              accept_s;
    logic [DATA_W-1:0] y_r;
    logic              y_is_imm_r;
    logic              out_valid_r;
    logic [DATA_W-1:0] skid_y_r;
    logic              skid_imm_r;
    logic              skid_valid_r;

    // Forwarding mux for the B operand; code 3 falls back to the register file.
    always_comb begin
        b_sel_s = bus.b_reg;
        case (bus.fwd_sel)
            FWD_REG: b_sel_s = bus.b_reg;
            FWD_MEM: b_sel_s = bus.b_fwd_mem;
            FWD_WB:  b_sel_s = bus.b_fwd_wb;
            default: b_sel_s = bus.b_reg;
        endcase
    end

    y_operand_sel #(
        .DATA_W    (DATA_W),
        .IMM_W     (IMM_W),
        .SHAMT_W   (SHAMT_W),
        .ZEXT_OP   (ZEXT_OP),
        .CONST_VAL (CONST_VAL)
    ) u_sel (
        .instruction (bus.instruction),
        .b_sel       (b_sel_s),
        .y_sel       (bus.y_sel),
        .next_y      (next_y_s),
        .next_imm    (next_imm_s)
    );

    // in_ready depends only on state, so the ALU's ready never loops back.
    assign bus.in_ready = ~skid_valid_r;
    assign accept_s     = bus.in_valid & ~skid_valid_r;

    // Output register and skid entry update.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_r          <= {DATA_W{1'b0}};
            y_is_imm_r   <= 1'b0;
            out_valid_r  <= 1'b0;
            skid_y_r     <= {DATA_W{1'b0}};
            skid_imm_r   <= 1'b0;
            skid_valid_r <= 1'b0;
        end else if (bus.flush) begin
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
        end else if (!out_valid_r || bus.out_ready) begin
            if (skid_valid_r) begin
                y_r          <= skid_y_r;
                y_is_imm_r   <= skid_imm_r;
                out_valid_r  <= 1'b1;
                skid_valid_r <= 1'b0;
            end else if (accept_s) begin
                y_r         <= next_y_s;
                y_is_imm_r  <= next_imm_s;
                out_valid_r <= 1'b1;
            end else begin
                out_valid_r <= 1'b0;
            end
        end else if (accept_s) begin
            skid_y_r     <= next_y_s;
            skid_imm_r   <= next_imm_s;
            skid_valid_r <= 1'b1;
        end
    end

    assign bus.Y         = y_r;
    assign bus.y_is_imm  = y_is_imm_r;
    assign bus.out_valid = out_valid_r;
endmodule

// File: doc/y_operand_stage.md
Name: y_operand_stage

Overview:
- Next-generation ALU second-operand (Y) generator for the EX stage.
- Widened mode set: B, shamt, zero, extended immediate, upper immediate, and a constant.
- Forwarding select on B.
- Registered output with a valid/ready handshake and a one-entry skid buffer, so the stage can stall and flush without dropping operands.
- Sits between the ID/EX register and the ALU B input.

Parameters:
- DATA_W, 32: operand and output width.
- IMM_W, 16: immediate field width, instruction[IMM_W-1:0].
- SHAMT_W, 5: shift-amount field width, instruction[6+SHAMT_W-1:6].
- ZEXT_OP, 5'b00110: value of instruction[31:27] that selects zero-extension of the immediate.
- CONST_VAL, 32'd4: constant driven in mode CONST.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: instruction/operands valid this cycle.
- in_ready, output, 1: stage can accept input.
- instruction, input, 32: instruction word.
- b_reg, input, DATA_W: register-file B value.
- b_fwd_mem, input, DATA_W: forwarded result from EX/MEM.
- b_fwd_wb, input, DATA_W: forwarded result from MEM/WB.
- fwd_sel, input, 2: 0 = b_reg, 1 = b_fwd_mem, 2 = b_fwd_wb, 3 = b_reg.
- y_sel, input, 3: mode; encodings in Behaviour.
- flush, input, 1: discard all held operands.
- out_valid, output, 1: Y valid.
- out_ready, input, 1: ALU consumes Y.
- Y, output, DATA_W: selected operand.
- y_is_imm, output, 1: registered flag; 1 when Y came from mode IMM or UPPER.

Behaviour:
- Combinational select (next_y):
  - Bsel = value picked by fwd_sel.
  - IMM: imm = instruction[IMM_W-1:0]. When instruction[31:27] == ZEXT_OP, zero-extend to DATA_W; otherwise sign-extend from bit IMM_W-1.
  - y_sel encodings:
    - 0 B: Bsel.
    - 1 SHAMT: zero-extended shamt.
    - 2 ZERO: all zeros.
    - 3 IMM: extended immediate as above.
    - 4 UPPER: imm placed in bits [DATA_W-1:DATA_W-IMM_W], zeros below.
    - 5 CONST: CONST_VAL.
    - 6, 7: all zeros; y_is_imm = 0.
- Storage: output register (Y, y_is_imm, out_valid) plus one skid entry (skid_y, skid_imm, skid_valid).
- in_ready = ~skid_valid, registered-derived with no combinational path from out_ready.
- accept = in_valid & in_ready. Latency is 1 cycle from accept to out_valid.
- Per-cycle update, in priority order:
  - rst: out_valid = 0, skid_valid = 0, Y = 0, y_is_imm = 0, skid contents = 0. in_ready reads 1 in the cycle after reset.
  - flush (rst low): out_valid = 0 and skid_valid = 0. Any same-cycle accept is dropped. Y holds its last value.
  - Output slot empty, or out_ready = 1: if skid_valid, move the skid entry to the output and clear skid_valid; a same-cycle accept cannot occur, since in_ready = 0. Otherwise, on accept, load next_y to the output with out_valid = 1. Otherwise out_valid = 0.
  - Output full and out_ready = 0: on accept, load next_y into the skid entry and set skid_valid = 1. The output holds.
- Y and y_is_imm must be stable while out_valid = 1 and out_ready = 0.
- Full throughput: back-to-back accepts with out_ready held at 1 give one output per cycle.
- flush and rst mid-stall discard both entries; no partial state survives.
- fwd_sel is only meaningful in mode B; it is ignored in all other modes.

Decomposition:
- Shared package: y_sel mode constants (Y_B, Y_SHAMT, Y_ZERO, Y_IMM, Y_UPPER, Y_CONST), fwd_sel constants (FWD_REG, FWD_MEM, FWD_WB).
- ZEXT_OP default lives with the opcode constants.
- Sub-module y_operand_sel: purely combinational next_y and y_is_imm from instruction, Bsel and y_sel.
- The handshake and skid logic stay in the top module.

Test Plan:
- Reset: hold rst 2 cycles with in_valid = 1 → out_valid = 0, Y = 0, and in_ready = 1 on the first cycle after rst falls.
- Immediate extension:
  - instruction[31:27] = 5'b00110, imm 16'h8001, y_sel 3 → Y = 32'h00008001 one cycle later, y_is_imm = 1.
  - Same imm with opcode 5'b10001 → Y = 32'hFFFF8001.
- Other modes:
  - y_sel 4 with imm 16'h1234 → Y = 32'h12340000.
  - y_sel 1 with instruction[10:6] = 5'd31 → Y = 32'd31.
  - y_sel 5 → Y = 32'd4.
- Forwarding: b_reg = 1, b_fwd_mem = 2, b_fwd_wb = 3, y_sel 0, fwd_sel 0..3 on four consecutive accepts with out_ready = 1 → Y = 1, 2, 3, 1 on consecutive cycles, out_valid held at 1.
- Stall/skid:
  - out_ready = 0 with two accepts (values A, B) → output holds A, the skid holds B, in_ready = 0, and a third in_valid is not accepted.
  - Raise out_ready → A then B delivered in order, and in_ready returns to 1 once the skid drains.
- Flush: during a stall with both entries full, pulse flush concurrent with in_valid → out_valid = 0 next cycle, skid empty, new input dropped, in_ready = 1.
